// File: rtl/storage_ctrl_mc.sv
// Storage controller: routes core requests to the local SRAM (with byte-enable RMW) or the external channel.
// Optional external wait timeout enabled by defining STORAGE_CTRL_TIMEOUT_EN.
module storage_ctrl_mc #(
  parameter int MEM_W       = 32,
  parameter int ADDR_W      = 32,
  parameter int SRAM_BYTES  = 8192,
  parameter int TIMEOUT_CYC = 1024,
  localparam int BE_W       = MEM_W / 8,
  localparam int SA_W       = $clog2(SRAM_BYTES / BE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [MEM_W-1:0]  wdata,
  output logic              gnt,
  output logic              rvalid,
  output logic [MEM_W-1:0]  rdata,
  output logic              err,
  output logic              sram_cen_n,
  output logic              sram_wen_n,
  output logic [SA_W-1:0]   sram_a,
  output logic [MEM_W-1:0]  sram_d,
  input  logic [MEM_W-1:0]  sram_q,
  output logic              ext_req,
  output logic              ext_we,
  output logic [BE_W-1:0]   ext_be,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [MEM_W-1:0]  ext_wdata,
  input  logic              ext_ack,
  input  logic [MEM_W-1:0]  ext_rdata
);

  localparam int BL = $clog2(BE_W);
  localparam logic [ADDR_W-1:0] SRAM_LIMIT = ADDR_W'(SRAM_BYTES);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SRAM_RD  = 3'd1;
  localparam logic [2:0] RMW_WR   = 3'd2;
  localparam logic [2:0] EXT_WAIT = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  if (!(MEM_W == 32 || MEM_W == 64) || (SRAM_BYTES & (SRAM_BYTES - 1)) != 0 || TIMEOUT_CYC < 1)
  begin : g_bad_params
    $error("storage_ctrl_mc: unsupported parameter set");
  end

  logic [2:0]       state;
  logic [SA_W-1:0]  cap_a;
  logic [BE_W-1:0]  cap_be;
  logic [MEM_W-1:0] cap_wdata;
  logic [MEM_W-1:0] merged;
  logic             is_sram;
  logic             be_full;
  logic             be_none;
  logic             tmo_hit;

  assign is_sram = addr < SRAM_LIMIT;
  assign be_full = &be;
  assign be_none = ~|be;

  // Handshake: a request is taken on any cycle with req && gnt; gnt is only offered in IDLE.
  // Each taken request produces exactly one single-cycle rvalid (rdata/err valid with it).
  // rvalid is registered as the FSM returns to IDLE, so the next gnt may coincide with it.
  assign gnt = req && (state == IDLE);

  always_comb begin
    for (int i = 0; i < BE_W; i++) begin
      merged[8*i +: 8] = cap_be[i] ? cap_wdata[8*i +: 8] : sram_q[8*i +: 8];
    end
  end

  always_comb begin
    sram_cen_n = 1'b1;
    sram_wen_n = 1'b1;
    sram_a     = cap_a;
    sram_d     = '0;
    if (state == IDLE) begin
      sram_a = addr[BL +: SA_W];
      sram_d = wdata;
      if (req && is_sram && !(we && be_none)) begin
        sram_cen_n = 1'b0;
        sram_wen_n = !(we && be_full);
      end
    end else if (state == RMW_WR) begin
      sram_cen_n = 1'b0;
      sram_wen_n = 1'b0;
      sram_d     = merged;
    end
  end

`ifdef STORAGE_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_cnt;

  // Counter sits at zero outside EXT_WAIT, so it always starts clean on entry.
  assign tmo_hit = (state == EXT_WAIT) && !ext_ack && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst || state != EXT_WAIT) tmo_cnt <= '0;
    else                           tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) err <= 1'b0;
    else      err <= tmo_hit;
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rvalid    <= 1'b0;
      rdata     <= '0;
      cap_a     <= '0;
      cap_be    <= '0;
      cap_wdata <= '0;
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_be    <= '0;
      ext_addr  <= '0;
      ext_wdata <= '0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            cap_a     <= addr[BL +: SA_W];
            cap_be    <= be;
            cap_wdata <= wdata;
            if (is_sram) begin
              if (!we)                    state <= SRAM_RD;
              else if (be_full || be_none) state <= RESP;
              else                        state <= RMW_WR;
            end else begin
              ext_req   <= 1'b1;
              ext_we    <= we;
              ext_be    <= be;
              ext_addr  <= addr;
              ext_wdata <= wdata;
              state     <= EXT_WAIT;
            end
          end
        end
        SRAM_RD: begin
          rdata  <= sram_q;
          rvalid <= 1'b1;
          state  <= IDLE;
        end
        RMW_WR: state <= RESP;
        RESP: begin
          rdata  <= '0;
          rvalid <= 1'b1;
          state  <= IDLE;
        end
        EXT_WAIT: begin
          if (ext_ack) begin
            ext_req <= 1'b0;
            rdata   <= ext_we ? '0 : ext_rdata;
            rvalid  <= 1'b1;
            state   <= IDLE;
          end else if (tmo_hit) begin
            ext_req <= 1'b0;
            rdata   <= '0;
            rvalid  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_storage_ctrl_mc.sv
// Bench for storage_ctrl_mc: directed vector table, multi-cycle corner sequences and random traffic
// checked against a word/byte-lane memory model with a response scoreboard.
module tb_storage_ctrl_mc;

  localparam int MEM_W = 32;
  localparam int ADDR_W = 32;
  localparam int SRAM_BYTES = 8192;
  localparam int TIMEOUT_CYC = 8;
  localparam int BE_W = MEM_W / 8;
  localparam int SA_W = 11;

  logic              clk;
  logic              rst;
  logic              req;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [ADDR_W-1:0] addr;
  logic [MEM_W-1:0]  wdata;
  logic              gnt;
  logic              rvalid;
  logic [MEM_W-1:0]  rdata;
  logic              err;
  logic              sram_cen_n;
  logic              sram_wen_n;
  logic [SA_W-1:0]   sram_a;
  logic [MEM_W-1:0]  sram_d;
  logic [MEM_W-1:0]  sram_q;
  logic              ext_req;
  logic              ext_we;
  logic [BE_W-1:0]   ext_be;
  logic [ADDR_W-1:0] ext_addr;
  logic [MEM_W-1:0]  ext_wdata;
  logic              ext_ack;
  logic [MEM_W-1:0]  ext_rdata;

  storage_ctrl_mc #(
    .MEM_W(MEM_W), .ADDR_W(ADDR_W), .SRAM_BYTES(SRAM_BYTES), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .sram_cen_n(sram_cen_n), .sram_wen_n(sram_wen_n), .sram_a(sram_a), .sram_d(sram_d),
    .sram_q(sram_q), .ext_req(ext_req), .ext_we(ext_we), .ext_be(ext_be),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bench SRAM (single port, registered read) ----------------
  logic [MEM_W-1:0] sram_mem [0:2047];
  int wen_cnt = 0;

  always @(posedge clk) begin
    if (!sram_cen_n) begin
      if (!sram_wen_n) begin
        sram_mem[sram_a] <= sram_d;
        wen_cnt <= wen_cnt + 1;
      end else begin
        sram_q <= sram_mem[sram_a];
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [MEM_W-1:0] ref_mem [0:2047];
  logic [MEM_W:0]   exp_q[$];
  logic [MEM_W-1:0] last_data;
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  function automatic logic [MEM_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
    return ref_mem[a[12:2]];
  endfunction

  function automatic void model_apply(input logic w, input logic [BE_W-1:0] b,
                                      input logic [ADDR_W-1:0] a, input logic [MEM_W-1:0] d);
    if (w && a < SRAM_BYTES) begin
      for (int i = 0; i < BE_W; i++)
        if (b[i]) ref_mem[a[12:2]][8*i +: 8] = d[8*i +: 8];
    end
  endfunction

  always @(negedge clk) begin
    if (rvalid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rvalid", {err, rdata}, '0);
      end else begin
        logic [MEM_W:0] e;
        e = exp_q.pop_front();
        chk("resp_err_rdata", {err, rdata}, e);
      end
    end
  end

  // ---------------- driver ----------------
  // delay < 0: never acknowledge the external request.
  task automatic txn(input logic w, input logic [BE_W-1:0] b, input logic [ADDR_W-1:0] a,
                     input logic [MEM_W-1:0] d, input int delay, input logic [MEM_W-1:0] xrd,
                     input logic [MEM_W-1:0] exp_d, input logic exp_e, input int exp_lat);
    int lat;
    int gw;
    int wen0;
    int exp_wen;
    bit is_ext;
    bit acked;
    bit done;
    bit hold_ok;
    is_ext  = (a >= SRAM_BYTES);
    exp_wen = (!is_ext && w && b != 0) ? 1 : 0;
    exp_q.push_back({exp_e, exp_d});
    model_apply(w, b, a, d);
    @(negedge clk);
    chk("rdata_hold", rdata, last_data);
    wen0 = wen_cnt;
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    #1;
    gw = 0;
    while (!gnt && gw < 8) begin
      @(negedge clk); #1; gw++;
    end
    chk("gnt", gnt, 1);
    @(negedge clk);
    req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    lat = 1; acked = 0; done = 0; hold_ok = 1;
    while (!done && lat < 64) begin
      #1;
      if (rvalid) begin
        done = 1;
      end else begin
        if (is_ext && !acked) begin
          if (!(ext_req && ext_addr == a && ext_we == w && ext_be == b && ext_wdata == d))
            hold_ok = 0;
          if (delay >= 0 && lat == 1 + delay) begin
            ext_ack = 1'b1; ext_rdata = xrd; acked = 1;
          end
        end
        @(negedge clk);
        ext_ack = 1'b0; ext_rdata = $urandom;
        lat++;
      end
    end
    chk("rvalid_seen", done, 1);
    chk("latency", lat, exp_lat);
    if (is_ext) begin
      chk("ext_hold", hold_ok, 1);
      chk("ext_req_drop", ext_req, 0);
    end
    chk("sram_writes", wen_cnt - wen0, exp_wen);
    last_data = exp_d;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             w;
    logic [BE_W-1:0]  b;
    logic [ADDR_W-1:0] a;
    logic [MEM_W-1:0] d;
    int               delay;
    logic [MEM_W-1:0] xrd;
    logic [MEM_W-1:0] exp_d;
    logic             exp_e;
    int               exp_lat;
  } vec_t;

  vec_t vecs [16];

  logic              rw;
  logic [BE_W-1:0]   rb;
  logic [ADDR_W-1:0] ra;
  logic [MEM_W-1:0]  rd, rx, ed;
  int                rdl, el, sel, n, gcyc [3];
  logic [ADDR_W-1:0] bb_addr [3];

  initial begin
    req = 0; we = 0; be = '0; addr = '0; wdata = '0;
    ext_ack = 0; ext_rdata = '0; rst = 1'b0; last_data = '0;
    for (int i = 0; i < 2048; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end

    vecs[0]  = '{1'b1, 4'hF, 32'h10,       32'hDEADBEEF, 0, 32'h0,        32'h0,        1'b0, 2};
    vecs[1]  = '{1'b0, 4'hF, 32'h10,       32'h0,        0, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    vecs[2]  = '{1'b0, 4'h0, 32'h13,       32'h0,        0, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    vecs[3]  = '{1'b1, 4'hF, 32'h20,       32'h11223344, 0, 32'h0,        32'h0,        1'b0, 2};
    vecs[4]  = '{1'b1, 4'h6, 32'h20,       32'hAABBCCDD, 0, 32'h0,        32'h0,        1'b0, 3};
    vecs[5]  = '{1'b0, 4'hF, 32'h20,       32'h0,        0, 32'h0,        32'h11BBCC44, 1'b0, 2};
    vecs[6]  = '{1'b1, 4'h0, 32'h20,       32'hFFFFFFFF, 0, 32'h0,        32'h0,        1'b0, 2};
    vecs[7]  = '{1'b0, 4'hF, 32'h20,       32'h0,        0, 32'h0,        32'h11BBCC44, 1'b0, 2};
    vecs[8]  = '{1'b1, 4'h1, 32'h20,       32'h000000EE, 0, 32'h0,        32'h0,        1'b0, 3};
    vecs[9]  = '{1'b0, 4'hF, 32'h20,       32'h0,        0, 32'h0,        32'h11BBCCEE, 1'b0, 2};
    vecs[10] = '{1'b1, 4'hF, 32'h1FFC,     32'h5A5A0001, 0, 32'h0,        32'h0,        1'b0, 2};
    vecs[11] = '{1'b0, 4'hF, 32'h1FFC,     32'h0,        0, 32'h0,        32'h5A5A0001, 1'b0, 2};
    vecs[12] = '{1'b0, 4'hF, 32'h2000,     32'h0,        5, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 7};
    vecs[13] = '{1'b1, 4'h3, 32'h40000004, 32'h12345678, 0, 32'hFFFFFFFF, 32'h0,        1'b0, 2};
    vecs[14] = '{1'b0, 4'hF, 32'hFFFFFFF0, 32'h0,        1, 32'h0BADC0DE, 32'h0BADC0DE, 1'b0, 3};
    vecs[15] = '{1'b0, 4'hF, 32'h0,        32'h0,        0, 32'h0,        32'h0,        1'b0, 2};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_handshake", {gnt, rvalid, err, ext_req, ext_we}, 5'b0);
    chk("reset_sram_strobes", {sram_cen_n, sram_wen_n}, 2'b11);
    chk("reset_rdata", rdata, 0);
    chk("reset_ext_fields", {ext_addr, ext_be, ext_wdata}, '0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++)
      txn(vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].d, vecs[i].delay, vecs[i].xrd,
          vecs[i].exp_d, vecs[i].exp_e, vecs[i].exp_lat);

    // stray ext_ack while idle must not produce a response
    @(negedge clk);
    ext_ack = 1'b1; ext_rdata = 32'h77777777;
    @(negedge clk);
    ext_ack = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("stray_ack_quiet", rvalid, 0);
    end

    // back-to-back reads with req held high
    bb_addr[0] = 32'h10; bb_addr[1] = 32'h20; bb_addr[2] = 32'h1FFC;
    @(negedge clk);
    req = 1'b1; we = 1'b0; be = 4'hF; addr = bb_addr[0];
    n = 0;
    for (int c = 0; c < 16 && n < 3; c++) begin
      #1;
      if (gnt) begin
        if (n > 0) chk("b2b_gnt_with_rvalid", rvalid, 1);
        gcyc[n] = c;
        exp_q.push_back({1'b0, ref_read(bb_addr[n])});
        n++;
      end
      @(negedge clk);
      if (n < 3) addr = bb_addr[n];
      else req = 1'b0;
    end
    req = 1'b0;
    chk("b2b_gnt_count", n, 3);
    chk("b2b_gap01", gcyc[1] - gcyc[0], 2);
    chk("b2b_gap12", gcyc[2] - gcyc[1], 2);
    repeat (4) @(negedge clk);
    chk("b2b_drained", exp_q.size(), 0);
    last_data = ref_read(bb_addr[2]);

    // reset while waiting on external storage
    @(negedge clk);
    chk("rst_rdata_before", rdata, last_data);
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h3000;
    #1 chk("rst_gnt", gnt, 1);
    @(negedge clk);
    req = 1'b0;
    #1 chk("rst_ext_req_up", ext_req, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("rst_ext_req_drop", {ext_req, rvalid}, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    last_data = '0;
    repeat (6) @(negedge clk);
    #1 chk("rst_no_rvalid", rvalid, 0);

`ifdef STORAGE_CTRL_TIMEOUT_EN
    txn(1'b0, 4'hF, 32'h5000, 32'h0, -1, 32'h0, 32'h0, 1'b1, TIMEOUT_CYC + 1);
    txn(1'b0, 4'hF, 32'h5004, 32'h0, TIMEOUT_CYC - 1, 32'h600DF00D, 32'h600DF00D, 1'b0,
        TIMEOUT_CYC + 1);
`else
    txn(1'b0, 4'hF, 32'h5000, 32'h0, 20, 32'h600DF00D, 32'h600DF00D, 1'b0, 22);
`endif

    // random traffic against the model
    for (int k = 0; k < 80; k++) begin
      rw  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      rb  = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom_range(0, 15));
      rd  = $urandom;
      rx  = $urandom;
      rdl = $urandom_range(0, 4);
      sel = $urandom_range(0, 9);
      if (sel < 6)      ra = ADDR_W'($urandom_range(0, 63));
      else if (sel < 7) ra = ADDR_W'($urandom_range(0, SRAM_BYTES - 1));
      else begin
        ra = $urandom;
        if (ra < SRAM_BYTES) ra = ra + SRAM_BYTES;
      end
      if (ra < SRAM_BYTES) begin
        ed = rw ? '0 : ref_read(ra);
        el = (rw && rb != 4'h0 && rb != 4'hF) ? 3 : 2;
      end else begin
        ed = rw ? '0 : rx;
        el = 2 + rdl;
      end
      txn(rw, rb, ra, rd, rdl, rx, ed, 1'b0, el);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
